// File: rtl/debounce_event_ctrl_if.sv
// Event handshake between the debouncer event controller and its consumer.
// The controller drives valid/idx/rise; the consumer answers with ready.
interface debounce_event_ctrl_if #(
    parameter int DW = 8
);
    localparam int IW = $clog2(DW);

    logic          evt_valid_o;
    logic          evt_ready_i;
    logic [IW-1:0] evt_idx_o;
    logic          evt_rise_o;

    modport master (
        output evt_valid_o,
        output evt_idx_o,
        output evt_rise_o,
        input  evt_ready_i
    );

    modport slave (
        input  evt_valid_o,
        input  evt_idx_o,
        input  evt_rise_o,
        output evt_ready_i
    );
endinterface

// File: rtl/debounce_event_ctrl.sv
// Debouncer bank controller: sample-enable prescaler, per-bit edge capture with
// one pending event per bit, and a round-robin arbiter onto one event port.
module debounce_event_ctrl #(
    parameter int DW       = 8,
    parameter int TICK_DIV = 1000,
    localparam int IW      = $clog2(DW)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable_i,
    input  logic [DW-1:0]          db_in,
    output logic                   en_o,
    debounce_event_ctrl_if.master  evt,
    output logic [DW-1:0]          pend_o,
    output logic                   overflow_o,
    input  logic                   clr_overflow_i
);

    localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [DW-1:0] prev;
    logic [DW-1:0] edges;
    logic [DW-1:0] pend;
    logic [DW-1:0] pol;
    logic [DW-1:0] grant_vec;
    logic          grant;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] ptr;
    logic [IW-1:0] idx_q;
    logic          rise_q;
    logic          overflow;
    logic          ovf_set;

    // The strobe is the terminal count itself, so disabling kills it at once.
    assign tick = enable_i && (cnt == CNT_LAST);
    assign en_o = tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!enable_i || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign edges     = db_in ^ prev;
    assign grant_vec = grant ? (DW'(1) << grant_idx) : '0;
    // Only a collision that the arbiter is not draining this cycle loses an event.
    assign ovf_set   = |(edges & pend & ~grant_vec);

    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        grant_idx = '0;
        case (state_q)
            IDLE: begin
                for (int k = DW; k >= 1; k--) begin
                    if (pend[IW'((int'(ptr) + k) % DW)]) begin
                        grant     = 1'b1;
                        grant_idx = IW'((int'(ptr) + k) % DW);
                    end
                end
                if (grant) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (evt.evt_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            prev     <= '0;
            pend     <= '0;
            pol      <= '0;
            ptr      <= IW'(DW - 1);
            idx_q    <= '0;
            rise_q   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev     <= db_in;
            pend     <= (pend & ~grant_vec) | edges;
            pol      <= (pol & ~edges) | (db_in & edges);
            overflow <= ovf_set | (overflow & ~clr_overflow_i);
            if (grant) begin
                idx_q  <= grant_idx;
                rise_q <= pol[grant_idx];
                ptr    <= grant_idx;
            end
        end
    end

    assign evt.evt_valid_o = (state_q == PRESENT);
    assign evt.evt_idx_o   = idx_q;
    assign evt.evt_rise_o  = rise_q;
    assign pend_o          = pend;
    assign overflow_o      = overflow;

endmodule

// File: tb/tb_debounce_event_ctrl.sv
// Directed bench for debounce_event_ctrl: prescaler, latency, round-robin order,
// backpressure, overflow set/clear race and asynchronous reset.
module tb_debounce_event_ctrl;

    localparam int DW       = 8;
    localparam int TICK_DIV = 4;
    localparam int IW       = $clog2(DW);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable_i = 1'b0;
    logic [DW-1:0] db_in = '0;
    logic          clr_overflow_i = 1'b0;
    logic          en_o;
    logic [DW-1:0] pend_o;
    logic          overflow_o;

    int n_compared   = 0;
    int n_mismatched = 0;

    debounce_event_ctrl_if #(.DW(DW)) evt ();

    debounce_event_ctrl #(
        .DW       (DW),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable_i       (enable_i),
        .db_in          (db_in),
        .en_o           (en_o),
        .evt            (evt.master),
        .pend_o         (pend_o),
        .overflow_o     (overflow_o),
        .clr_overflow_i (clr_overflow_i)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic apply_reset();
        rst             = 1'b0;
        enable_i        = 1'b0;
        db_in           = '0;
        clr_overflow_i  = 1'b0;
        evt.evt_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Waits (bounded) for a presented event, checks it, then advances one cycle.
    task automatic expect_event(input string tag, input int exp_idx, input logic exp_rise);
        int budget = 20;
        while (!evt.evt_valid_o && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_output({tag, " valid"}, 32'(evt.evt_valid_o), 32'd1);
        check_output({tag, " idx"},   32'(evt.evt_idx_o),   32'(exp_idx));
        check_output({tag, " rise"},  32'(evt.evt_rise_o),  32'(exp_rise));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        evt.evt_ready_i = 1'b0;

        // Reset state
        #2;
        check_output("reset en_o",     32'(en_o),            32'd0);
        check_output("reset valid",    32'(evt.evt_valid_o), 32'd0);
        check_output("reset idx",      32'(evt.evt_idx_o),   32'd0);
        check_output("reset rise",     32'(evt.evt_rise_o),  32'd0);
        check_output("reset pend",     32'(pend_o),          32'd0);
        check_output("reset overflow", 32'(overflow_o),      32'd0);
        apply_reset();

        // Prescaler: pulses every fourth cycle after enable rises
        enable_i = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            #1;
            check_output($sformatf("tick run k=%0d", k), 32'(en_o), 32'((k % 4) == 0));
            @(negedge clk);
        end
        for (int k = 1; k <= 9; k++) begin
            #1;
            check_output($sformatf("tick pre k=%0d", k), 32'(en_o), 32'((k % 4) == 0));
            @(negedge clk);
        end
        enable_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            check_output($sformatf("tick off k=%0d", k), 32'(en_o), 32'd0);
            @(negedge clk);
        end
        enable_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            #1;
            check_output($sformatf("tick re k=%0d", k), 32'(en_o), 32'((k % 4) == 0));
            @(negedge clk);
        end
        enable_i = 1'b0;

        // Single press then release on bit 3
        evt.evt_ready_i = 1'b1;
        db_in[3] = 1'b1;
        @(negedge clk);
        check_output("press pend",   32'(pend_o),          32'h08);
        check_output("press early",  32'(evt.evt_valid_o), 32'd0);
        @(negedge clk);
        check_output("press valid",  32'(evt.evt_valid_o), 32'd1);
        check_output("press idx",    32'(evt.evt_idx_o),   32'd3);
        check_output("press rise",   32'(evt.evt_rise_o),  32'd1);
        check_output("press unpend", 32'(pend_o),          32'h00);
        @(negedge clk);
        check_output("press done",   32'(evt.evt_valid_o), 32'd0);
        db_in[3] = 1'b0;
        @(negedge clk);
        check_output("release pend", 32'(pend_o),          32'h08);
        @(negedge clk);
        check_output("release valid", 32'(evt.evt_valid_o), 32'd1);
        check_output("release idx",   32'(evt.evt_idx_o),   32'd3);
        check_output("release rise",  32'(evt.evt_rise_o),  32'd0);
        @(negedge clk);
        check_output("release done",  32'(evt.evt_valid_o), 32'd0);
        check_output("single ovf",    32'(overflow_o),      32'd0);

        // Round-robin from a fresh pointer
        apply_reset();
        evt.evt_ready_i = 1'b1;
        db_in = 8'b0010_0101;
        expect_event("rr first", 0, 1'b1);
        check_output("rr pend left", 32'(pend_o), 32'h24);
        expect_event("rr second", 2, 1'b1);
        expect_event("rr third", 5, 1'b1);
        db_in = db_in | 8'b0100_0010;
        expect_event("rr wrap a", 6, 1'b1);
        expect_event("rr wrap b", 1, 1'b1);
        check_output("rr ovf", 32'(overflow_o), 32'd0);

        // Backpressure on bit 2 with collisions
        apply_reset();
        db_in[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) db_in[2] = 1'b0;
            if (i == 6) db_in[2] = 1'b1;
            @(negedge clk);
            check_output($sformatf("bp valid i=%0d", i), 32'(evt.evt_valid_o), 32'd1);
            check_output($sformatf("bp idx i=%0d", i),   32'(evt.evt_idx_o),   32'd2);
            check_output($sformatf("bp rise i=%0d", i),  32'(evt.evt_rise_o),  32'd1);
            if (i == 2) begin
                check_output("bp pend first", 32'(pend_o),     32'h04);
                check_output("bp ovf first",  32'(overflow_o), 32'd0);
            end
            if (i == 6) begin
                check_output("bp pend second", 32'(pend_o),     32'h04);
                check_output("bp ovf second",  32'(overflow_o), 32'd1);
            end
        end
        evt.evt_ready_i = 1'b1;
        @(negedge clk);
        evt.evt_ready_i = 1'b0;
        check_output("bp accepted", 32'(evt.evt_valid_o), 32'd0);
        expect_event("bp latest pol", 2, 1'b1);
        check_output("bp ovf sticky", 32'(overflow_o), 32'd1);

        // Overflow clear alone, then a clear racing a new overflow
        clr_overflow_i = 1'b1;
        @(negedge clk);
        clr_overflow_i = 1'b0;
        check_output("clr alone", 32'(overflow_o), 32'd0);
        db_in[2] = 1'b0;
        @(negedge clk);
        check_output("race pend", 32'(pend_o),     32'h04);
        check_output("race pre",  32'(overflow_o), 32'd0);
        db_in[2]       = 1'b1;
        clr_overflow_i = 1'b1;
        @(negedge clk);
        clr_overflow_i = 1'b0;
        check_output("race set wins", 32'(overflow_o), 32'd1);

        // Asynchronous reset while presenting
        check_output("pre-reset valid", 32'(evt.evt_valid_o), 32'd1);
        #2;
        rst   = 1'b0;
        db_in = '0;
        #1;
        check_output("async valid", 32'(evt.evt_valid_o), 32'd0);
        check_output("async idx",   32'(evt.evt_idx_o),   32'd0);
        check_output("async rise",  32'(evt.evt_rise_o),  32'd0);
        check_output("async pend",  32'(pend_o),          32'd0);
        check_output("async ovf",   32'(overflow_o),      32'd0);
        check_output("async en",    32'(en_o),            32'd0);
        @(negedge clk);
        rst = 1'b1;
        evt.evt_ready_i = 1'b1;
        db_in = 8'b1000_0010;
        expect_event("post-reset first", 1, 1'b1);
        expect_event("post-reset second", 7, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
